// File: rtl/calc_cmd_feeder.sv
// Command feeder for a stack-style queue calculator.
// Buffers upstream commands in a small FIFO, pre-checks each head command
// against a model of the calculator's occupancy, issues legal commands one
// at a time and confirms the calculator's response before issuing the next.
module calc_cmd_feeder #(
    parameter int WIDTH      = 8,
    parameter int QUEUE_SIZE = 5,
    parameter int DEPTH      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic [2:0]       s_op,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] in,
    output logic [2:0]       op,
    output logic             apply,
    input  logic             calc_valid,
    input  logic             calc_empty,
    output logic [2:0]       level,
    output logic             rejected,
    output logic             fault,
    output logic [7:0]       issued_cnt,
    output logic [7:0]       reject_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = WIDTH + 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;

    state_t           state_q, state_d;
    logic [EW-1:0]    fifo_mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] in_q, in_d;
    logic [2:0]       op_q, op_d;
    logic             apply_q, apply_d;
    logic [2:0]       level_q, level_d;
    logic             rejected_q, rejected_d;
    logic             fault_q, fault_d;
    logic [7:0]       issued_q, issued_d;
    logic [7:0]       reject_q, reject_d;

    logic             fifo_full, fifo_empty, wr_en, pop, flush, head_illegal;
    logic [EW-1:0]    head;
    logic [2:0]       head_op;
    logic [WIDTH-1:0] head_data;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign s_ready    = !fifo_full && (state_q != HALT);
    assign wr_en      = s_valid && s_ready;
    assign head       = fifo_mem_q[rd_ptr_q];
    assign head_op    = head[2:0];
    assign head_data  = head[EW-1:3];

    assign in         = in_q;
    assign op         = op_q;
    assign apply      = apply_q;
    assign level      = level_q;
    assign rejected   = rejected_q;
    assign fault      = fault_q;
    assign issued_cnt = issued_q;
    assign reject_cnt = reject_q;

    // Decide whether the head command could be executed at the current occupancy.
    always_comb begin
        head_illegal = 1'b0;
        case (head_op)
            3'd0:    head_illegal = (level_q == 3'(QUEUE_SIZE));
            3'd1:    head_illegal = (level_q == 3'd0);
            3'd7:    head_illegal = 1'b1;
            default: head_illegal = (level_q < 3'd2);
        endcase
    end

    // FIFO storage: plain write port, no reset needed on the data array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem_q[wr_ptr_q] <= {s_data, s_op};
        end
    end

    // FIFO pointers and occupancy; a flush wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            in_q       <= '0;
            op_q       <= '0;
            apply_q    <= 1'b0;
            level_q    <= '0;
            rejected_q <= 1'b0;
            fault_q    <= 1'b0;
            issued_q   <= '0;
            reject_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_q       <= in_d;
            op_q       <= op_d;
            apply_q    <= apply_d;
            level_q    <= level_d;
            rejected_q <= rejected_d;
            fault_q    <= fault_d;
            issued_q   <= issued_d;
            reject_q   <= reject_d;
        end
    end

    // Next-state logic: pre-check/pop in IDLE, strobe in ISSUE, verify in WAIT.
    always_comb begin
        state_d    = state_q;
        in_d       = in_q;
        op_d       = op_q;
        apply_d    = 1'b0;
        level_d    = level_q;
        rejected_d = rejected_q;
        fault_d    = fault_q;
        issued_d   = issued_q;
        reject_d   = reject_q;
        pop        = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_illegal) begin
                        rejected_d = 1'b1;
                        reject_d   = (reject_q == 8'hFF) ? reject_q : reject_q + 8'd1;
                    end else begin
                        in_d    = head_data;
                        op_d    = head_op;
                        apply_d = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!calc_valid) begin
                    fault_d = 1'b1;
                    flush   = 1'b1;
                    state_d = HALT;
                end else begin
                    level_d  = (op_q == 3'd0) ? level_q + 3'd1 : level_q - 3'd1;
                    issued_d = issued_q + 8'd1;
                    if (calc_empty != (level_d == 3'd0)) begin
                        fault_d = 1'b1;
                        flush   = 1'b1;
                        state_d = HALT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                flush = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_cmd_feeder.sv
// Scoreboard bench for calc_cmd_feeder: a behavioural calculator answers each
// apply, a stack-based reference model predicts every issue/reject at accept time.
module tb_calc_cmd_feeder;
    localparam int WIDTH = 8;
    localparam int QS    = 5;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] s_data = '0;
    logic [2:0]       s_op = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] dut_in;
    logic [2:0]       dut_op;
    logic             apply;
    logic             calc_valid = 1'b0;
    logic             calc_empty = 1'b1;
    logic [2:0]       level;
    logic             rejected, fault;
    logic [7:0]       issued_cnt, reject_cnt;

    calc_cmd_feeder #(.WIDTH(WIDTH), .QUEUE_SIZE(QS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_op(s_op), .s_valid(s_valid),
        .s_ready(s_ready), .in(dut_in), .op(dut_op), .apply(apply),
        .calc_valid(calc_valid), .calc_empty(calc_empty), .level(level),
        .rejected(rejected), .fault(fault), .issued_cnt(issued_cnt), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // Reference model: calculator stack contents as seen in command order.
    int               m_stack[$];
    int               m_issued, m_rej;
    bit               m_rejected, m_fault, m_halt;
    bit               inject_mismatch;
    logic [WIDTH+2:0] exp_q[$];

    function automatic int arith(int o, int a, int b);
        int r;
        case (o)
            2:       r = a + b;
            3:       r = a * b;
            4:       r = a - b;
            5:       r = a / b;
            default: r = a % b;
        endcase
        return r & ((1 << WIDTH) - 1);
    endfunction

    function automatic void model_clear();
        m_stack.delete();
        exp_q.delete();
        m_issued = 0; m_rej = 0;
        m_rejected = 0; m_fault = 0; m_halt = 0;
        inject_mismatch = 0;
    endfunction

    // Operands: a = top of stack, b = the entry below it (the divisor for div/mod).
    function automatic void model_accept(logic [WIDTH-1:0] d, logic [2:0] o);
        int n;
        bit legal;
        int a, b;
        if (m_halt) return;
        n = m_stack.size();
        case (o)
            3'd0:    legal = (n < QS);
            3'd1:    legal = (n > 0);
            3'd7:    legal = 0;
            default: legal = (n >= 2);
        endcase
        if (!legal) begin
            if (m_rej < 255) m_rej++;
            m_rejected = 1;
            return;
        end
        exp_q.push_back({d, o});
        if ((o == 3'd5 || o == 3'd6) && m_stack[n-2] == 0) begin
            m_fault = 1; m_halt = 1;
            return;
        end
        if (o == 3'd0) m_stack.push_back(int'(d));
        else if (o == 3'd1) void'(m_stack.pop_back());
        else begin
            a = m_stack.pop_back();
            b = m_stack.pop_back();
            m_stack.push_back(arith(int'(o), a, b));
        end
        m_issued++;
        if (inject_mismatch) begin
            m_fault = 1; m_halt = 1; inject_mismatch = 0;
        end
    endfunction

    // Record every accepted command into the model.
    always @(posedge clk) begin
        if (!reset && s_valid && s_ready) model_accept(s_data, s_op);
    end

    // Behavioural calculator: answers an apply in the following (WAIT) cycle.
    int c_stack[$];
    bit lie_next = 0;
    always @(negedge clk) begin
        int a, b;
        bit ok;
        if (reset) begin
            c_stack.delete();
            calc_valid = 1'b0;
            calc_empty = 1'b1;
        end else if (apply) begin
            ok = 1;
            if (dut_op == 3'd0) begin
                if (c_stack.size() < QS) c_stack.push_back(int'(dut_in)); else ok = 0;
            end else if (dut_op == 3'd1) begin
                if (c_stack.size() > 0) void'(c_stack.pop_back()); else ok = 0;
            end else if (dut_op == 3'd7 || c_stack.size() < 2) begin
                ok = 0;
            end else begin
                a = c_stack.pop_back();
                b = c_stack.pop_back();
                if ((dut_op == 3'd5 || dut_op == 3'd6) && b == 0) ok = 0;
                else c_stack.push_back(arith(int'(dut_op), a, b));
            end
            calc_valid = ok;
            calc_empty = (c_stack.size() == 0) ^ lie_next;
            lie_next   = 0;
        end
    end

    // Monitor: every apply must match the next expected command and last one cycle.
    int cycle = 0;
    int apply_cycles[$];
    bit prev_apply = 0;
    always @(negedge clk) begin
        logic [WIDTH+2:0] e;
        cycle++;
        if (!reset && apply) begin
            apply_cycles.push_back(cycle);
            check("apply_single_cycle", 32'(prev_apply), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_apply: got in=%0d op=%0d, required no apply", dut_in, dut_op);
            end else begin
                e = exp_q.pop_front();
                check("apply_cmd", {dut_in, dut_op}, e);
            end
        end
        prev_apply = apply;
    end

    int stall_cycles = 0;

    task automatic send(logic [WIDTH-1:0] d, logic [2:0] o);
        int  t;
        bit  acc;
        t = 0;
        s_data = d; s_op = o; s_valid = 1'b1;
        forever begin
            @(posedge clk);
            acc = s_ready;
            @(negedge clk);
            if (acc) break;
            stall_cycles++;
            t++;
            if (t > 100) begin
                if (!m_halt) begin
                    n_checks++;
                    $display("FAIL accept_timeout: got s_ready=0 for 100 cycles, required acceptance");
                end
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; s_valid = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
        lie_next = 0;
        reset = 1'b0;
        check("rst_in", 32'(dut_in), 0);
        check("rst_op", 32'(dut_op), 0);
        check("rst_apply", 32'(apply), 0);
        check("rst_level", 32'(level), 0);
        check("rst_rejected", 32'(rejected), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_issued", 32'(issued_cnt), 0);
        check("rst_reject_cnt", 32'(reject_cnt), 0);
        check("rst_s_ready", 32'(s_ready), 1);
    endtask

    task automatic settle_and_check(string name);
        repeat (40) @(negedge clk);
        check({name, "_level"}, 32'(level), 32'(m_stack.size()));
        check({name, "_issued"}, 32'(issued_cnt), 32'(m_issued & 255));
        check({name, "_reject_cnt"}, 32'(reject_cnt), 32'(m_rej));
        check({name, "_rejected"}, 32'(rejected), 32'(m_rejected));
        check({name, "_fault"}, 32'(fault), 32'(m_fault));
        check({name, "_s_ready"}, 32'(s_ready), 32'(!m_halt));
        check({name, "_pending"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Push 3, push 4, add: three issues, three cycles apart.
        do_reset();
        apply_cycles.delete();
        send(8'd3, 3'd0); send(8'd4, 3'd0); send(8'd0, 3'd2);
        settle_and_check("basic");
        check("basic_level_const", 32'(level), 1);
        check("basic_issued_const", 32'(issued_cnt), 3);
        check("basic_apply_count", 32'(apply_cycles.size()), 3);
        if (apply_cycles.size() == 3) begin
            check("basic_spacing1", 32'(apply_cycles[1] - apply_cycles[0]), 3);
            check("basic_spacing2", 32'(apply_cycles[2] - apply_cycles[1]), 3);
        end

        // Pop on empty is rejected; a following push still issues.
        do_reset();
        send(8'd0, 3'd1); send(8'd7, 3'd0);
        settle_and_check("pop_empty");
        check("pop_empty_reject_const", 32'(reject_cnt), 1);

        // Six pushes: the sixth overflows the calculator and is rejected.
        do_reset();
        for (int i = 1; i <= 6; i++) send(8'(i), 3'd0);
        settle_and_check("overflow");
        check("overflow_level_const", 32'(level), 5);

        // Divide by zero: calculator drops valid, feeder halts and flushes.
        do_reset();
        send(8'd0, 3'd0); send(8'd9, 3'd0); send(8'd0, 3'd5);
        send(8'd1, 3'd0); send(8'd2, 3'd0);
        settle_and_check("div0");
        check("div0_fault_const", 32'(fault), 1);
        check("div0_s_ready_const", 32'(s_ready), 0);
        do_reset();

        // Calculator reports the wrong empty flag: mismatch fault, level still updated.
        do_reset();
        inject_mismatch = 1; lie_next = 1;
        send(8'd5, 3'd0);
        settle_and_check("mismatch");

        // Back-pressure: burst of commands fills the FIFO while the first is pending.
        do_reset();
        stall_cycles = 0;
        for (int i = 1; i <= 5; i++) send(8'(i * 10), 3'd0);
        send(8'd0, 3'd1); send(8'd0, 3'd1); send(8'd0, 3'd2);
        settle_and_check("burst");
        check("burst_backpressure", 32'(stall_cycles > 0), 1);

        // Reset in the ISSUE cycle aborts the command.
        do_reset();
        send(8'd7, 3'd0);
        t = 0;
        while (!apply && t < 10) begin @(negedge clk); t++; end
        check("abort_saw_apply", 32'(apply), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_apply", 32'(apply), 0);
        check("abort_level", 32'(level), 0);
        check("abort_issued", 32'(issued_cnt), 0);
        do_reset();

        // Randomized rounds against the reference model.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int k = 0; k < 40; k++) begin
                logic [2:0]       o;
                logic [WIDTH-1:0] d;
                if (m_halt) break;
                o = ($urandom_range(0, 9) < 4) ? 3'd0 : 3'($urandom_range(1, 7));
                d = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom_range(0, 255));
                send(d, o);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            settle_and_check("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_cmd_feeder.md
CALC_CMD_FEEDER -- requirements
Module: calc_cmd_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width matching the downstream queue calculator.
REQ-002 The block SHALL have parameter QUEUE_SIZE, default 5, calculator queue capacity used by the occupancy model.
REQ-003 The block SHALL have parameter DEPTH, default 4, command FIFO entries.
REQ-004 The block SHALL have ports as follows (one per line: name, direction, width, meaning):
  clk  input  1  single clock, all logic on posedge
  reset  input  1  synchronous, active-high; shared with the calculator
  s_data  input  WIDTH  command operand
  s_op  input  3  command opcode (0 push, 1 pop, 2 add, 3 mul, 4 sub, 5 div, 6 mod, 7 illegal)
  s_valid  input  1  upstream command present
  s_ready  output  1  feeder accepts command this cycle
  in  output  WIDTH  operand to calculator, registered
  op  output  3  opcode to calculator, registered
  apply  output  1  one-cycle issue strobe to calculator, registered
  calc_valid  input  1  calculator valid flag
  calc_empty  input  1  calculator empty flag
  level  output  3  modelled calculator occupancy, 0..QUEUE_SIZE
  rejected  output  1  sticky: at least one command dropped by pre-check
  fault  output  1  sticky: calculator error or model mismatch; feeder halted
  issued_cnt  output  8  commands issued, wraps 255->0
  reject_cnt  output  8  commands dropped, saturates at 255

Function
REQ-005 FIFO SHALL store {s_data,s_op}; write when s_valid && s_ready; s_ready = !fifo_full && state!=HALT.
REQ-006 States SHALL be IDLE, ISSUE, WAIT, HALT.
REQ-007 In IDLE with FIFO non-empty, head SHALL be pre-checked against level: op0 illegal if level==QUEUE_SIZE; op1 illegal if level==0; op2..6 illegal if level<2; op7 always illegal.
REQ-008 Illegal head SHALL be popped, reject_cnt incremented (saturating), rejected set, state stays IDLE; no apply.
REQ-009 Legal head SHALL be popped, in/op loaded, state -> ISSUE.
REQ-010 In ISSUE, apply SHALL be 1 for exactly that cycle; next state WAIT; apply is 0 in every other state.
REQ-011 In WAIT, calc_valid==0 SHALL set fault, -> HALT.
REQ-012 Otherwise in WAIT, level SHALL update (op0 +1; op1..6 -1), issued_cnt +1, -> IDLE.
REQ-013 In WAIT, if calc_empty != (updated level==0), fault SHALL be set and state -> HALT (mismatch), level still updated.
REQ-014 Minimum throughput SHALL be one issued command per 3 cycles; one rejected command per cycle.
REQ-015 Entering HALT SHALL flush the FIFO; HALT SHALL be left only by reset.
REQ-016 Write while FIFO empty and IDLE SHALL be seen at earliest on the next cycle (no bypass).
REQ-017 Simultaneous FIFO write and pop SHALL both take effect; count unchanged.
REQ-018 Division by zero SHALL NOT be pre-checked; it surfaces via calc_valid per REQ-011.

Reset
REQ-019 Reset SHALL force: state IDLE, FIFO empty, in=0, op=0, apply=0, level=0, rejected=0, fault=0, issued_cnt=0, reject_cnt=0; s_ready=1 the cycle after.
REQ-020 Reset during ISSUE or WAIT SHALL abort the command with no counter update; reset has priority over all other events.

Verification
REQ-021 Push 3, push 4, add -> apply pulses on cycles 3,6,9 after first accept; level 1,2,1; issued_cnt=3; fault=0.
REQ-022 Pop with level 0 -> no apply, rejected=1, reject_cnt=1, level=0; following push 7 still issues.
REQ-023 Six pushes (values 1..6) -> first five issue, level=5; sixth rejected; reject_cnt=1.
REQ-024 Push 0, push 9, div (calculator drops valid) -> fault=1, state HALT, s_ready=0, pending FIFO entries flushed; reset restores all REQ-019 values.
REQ-025 Fill FIFO with 4 commands while first in WAIT -> s_ready=0 at 4 entries, no command lost or duplicated; s_valid held sees acceptance when an entry pops.
REQ-026 Assert reset in ISSUE cycle of a push -> apply=0 next cycle, level=0, issued_cnt=0.
